// File: rtl/hs_port_arbiter_pkg.sv
// Shared types and defaults for the hiscore RAM port arbiter.
package hs_port_arbiter_pkg;

  // Hiscore region is 2**DEFAULT_ADDR_W bytes.
  localparam int DEFAULT_ADDR_W   = 6;
  // Cycles to wait after the core reports paused before touching the port.
  localparam int DEFAULT_PAUSEPAD = 2;
  localparam int DEFAULT_CSUM_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE_WAIT,
    ST_PAD,
    ST_DL,
    ST_UL,
    ST_SCAN_RD,
    ST_SCAN_ACC,
    ST_RELEASE
  } state_t;

  // True in the states that read the region for the change scan.
  function automatic logic is_scan_state(state_t s);
    return (s == ST_SCAN_RD) || (s == ST_SCAN_ACC);
  endfunction

endpackage

// File: rtl/hs_port_arbiter_scan.sv
// Change-scanner datapath: walks the hiscore region, sums the bytes and
// compares the result against the checksum recorded by the previous scan.
module hs_scan_csum
  import hs_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CSUM_W = DEFAULT_CSUM_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_acc,
  input  logic              i_abort,
  input  logic              i_resync,
  input  logic [7:0]        i_rd_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done,
  output logic              o_changed,
  output logic              o_csum_valid,
  output logic [CSUM_W-1:0] o_stored_csum
);

  logic [ADDR_W-1:0] r_addr;
  logic [CSUM_W-1:0] r_acc;
  logic [CSUM_W-1:0] r_stored;
  logic              r_valid;
  logic              r_changed;
  logic              r_active;

  logic              w_last;
  logic              w_step;
  logic [CSUM_W-1:0] w_sum;

  assign w_last = &r_addr;
  assign w_step = i_acc && r_active && !i_abort;
  assign w_sum  = r_acc + CSUM_W'(i_rd_data);

  assign o_addr        = r_addr;
  assign o_done        = w_step && w_last;
  assign o_changed     = r_changed;
  assign o_csum_valid  = r_valid;
  assign o_stored_csum = r_stored;

  // Address walk and accumulation; an abort leaves the accumulator and the
  // stored checksum untouched, the next start clears the walk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_acc    <= '0;
      r_stored <= '0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_addr   <= '0;
      r_acc    <= '0;
      r_active <= 1'b1;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (w_step) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_stored <= w_sum;
        r_valid  <= 1'b1;
        r_active <= 1'b0;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Single-cycle change flag; suppressed until a trusted baseline exists.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_step && w_last && r_valid && !i_resync && (w_sum != r_stored);
    end
  end

endmodule

// File: rtl/hs_port_arbiter.sv
// Arbitrates the core's hiscore RAM port between NVRAM download, NVRAM
// upload and the autosave change-scanner, and owns the CPU pause handshake.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no access pending, pause not requested
// PAUSE_WAIT  | pause requested, waiting for the core to halt
// PAD         | core halted, settling for PAUSEPAD cycles
// DL          | download writes passed straight through to the core
// UL          | upload reads: host address to core, data registered back
// SCAN_RD     | scanner presents its address
// SCAN_ACC    | scanner accumulates the byte returned by the core
// RELEASE     | pause dropped, waiting for the core to resume
module hs_port_arbiter
  import hs_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int PAUSEPAD = DEFAULT_PAUSEPAD,
  parameter int CSUM_W   = DEFAULT_CSUM_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  input  logic              ul_active,
  input  logic [ADDR_W-1:0] ul_addr,
  output logic [7:0]        ul_data,
  output logic              ul_wait,
  input  logic              autosave_en,
  input  logic              osd_open,
  output logic              pause_req,
  input  logic              paused,
  output logic [ADDR_W-1:0] hs_address,
  output logic [7:0]        hs_data_in,
  output logic              hs_write,
  input  logic [7:0]        hs_data_out,
  output logic              upload_req,
  output logic              busy
);

  localparam int PAD_W = (PAUSEPAD < 2) ? 1 : $clog2(PAUSEPAD + 1);
  localparam logic [PAD_W-1:0] PAD_LOAD = PAD_W'(PAUSEPAD);

  state_t            r_state;
  state_t            w_next;
  logic [PAD_W-1:0]  r_pad_cnt;
  logic              r_osd_d;
  logic              r_scan_req;
  logic              r_resync;
  logic              r_pause_req;
  logic [7:0]        r_ul_data;

  logic              w_pad_load;
  logic              w_scan_start;
  logic              w_any_req;
  logic              w_osd_rise;
  logic              w_abort;
  logic              w_scan_done;
  logic              w_changed;
  logic              w_csum_valid;
  logic [ADDR_W-1:0] w_scan_addr;
  logic [CSUM_W-1:0] w_stored_csum;

  assign w_osd_rise = osd_open && !r_osd_d && autosave_en;
  assign w_any_req  = dl_active || ul_active || r_scan_req;
  assign w_abort    = is_scan_state(r_state) && (dl_active || ul_active);

  hs_scan_csum #(
    .ADDR_W (ADDR_W),
    .CSUM_W (CSUM_W)
  ) u_scan (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (w_scan_start),
    .i_acc         (r_state == ST_SCAN_ACC),
    .i_abort       (w_abort),
    .i_resync      (r_resync),
    .i_rd_data     (hs_data_out),
    .o_addr        (w_scan_addr),
    .o_done        (w_scan_done),
    .o_changed     (w_changed),
    .o_csum_valid  (w_csum_valid),
    .o_stored_csum (w_stored_csum)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; preemption by the host jumps straight into DL/UL
  // because the core is already halted.
  always_comb begin
    w_next       = r_state;
    w_pad_load   = 1'b0;
    w_scan_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next = ST_PAUSE_WAIT;
      end
      ST_PAUSE_WAIT: begin
        if (paused) begin
          w_next     = ST_PAD;
          w_pad_load = 1'b1;
        end
      end
      ST_PAD: begin
        // Terminal count at 1 so PAD lasts PAUSEPAD cycles (minimum one).
        if (r_pad_cnt <= PAD_W'(1)) begin
          if (dl_active)       w_next = ST_DL;
          else if (ul_active)  w_next = ST_UL;
          else if (r_scan_req) begin
            w_next       = ST_SCAN_RD;
            w_scan_start = 1'b1;
          end else             w_next = ST_RELEASE;
        end
      end
      ST_DL: begin
        if (!dl_active) w_next = ST_RELEASE;
      end
      ST_UL: begin
        if (!ul_active) w_next = ST_RELEASE;
      end
      ST_SCAN_RD: begin
        if (dl_active)      w_next = ST_DL;
        else if (ul_active) w_next = ST_UL;
        else                w_next = ST_SCAN_ACC;
      end
      ST_SCAN_ACC: begin
        if (dl_active)        w_next = ST_DL;
        else if (ul_active)   w_next = ST_UL;
        else if (w_scan_done) w_next = ST_RELEASE;
        else                  w_next = ST_SCAN_RD;
      end
      ST_RELEASE: begin
        if (paused && w_any_req) w_next = ST_PAUSE_WAIT;
        else if (!paused)        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Pad down-counter, loaded when the core acknowledges the pause.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_cnt <= '0;
    end else if (w_pad_load) begin
      r_pad_cnt <= PAD_LOAD;
    end else if ((r_state == ST_PAD) && (r_pad_cnt != '0)) begin
      r_pad_cnt <= r_pad_cnt - 1'b1;
    end
  end

  // Scan request latch and resync flag; both persist until a scan finishes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_osd_d    <= 1'b0;
      r_scan_req <= 1'b0;
      r_resync   <= 1'b0;
    end else begin
      r_osd_d <= osd_open;
      if (w_osd_rise)       r_scan_req <= 1'b1;
      else if (w_scan_done) r_scan_req <= 1'b0;
      if ((r_state == ST_DL) && !dl_active) r_resync <= 1'b1;
      else if (w_scan_done)                 r_resync <= 1'b0;
    end
  end

  // Pause request: held from PAUSE_WAIT through the first RELEASE cycle,
  // dropped while RELEASE waits; a return to PAUSE_WAIT keeps it high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pause_req <= 1'b0;
    end else begin
      r_pause_req <= (w_next != ST_IDLE) &&
                     !((r_state == ST_RELEASE) && (w_next == ST_RELEASE));
    end
  end

  // Upload data follows the core's read port every UL cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_ul_data <= '0;
    else if (r_state == ST_UL)  r_ul_data <= hs_data_out;
  end

  // Port mux; download is pure pass-through so no write is ever in flight.
  always_comb begin
    hs_address = '0;
    hs_data_in = '0;
    hs_write   = 1'b0;
    case (r_state)
      ST_DL: begin
        hs_address = dl_addr;
        hs_data_in = dl_data;
        hs_write   = dl_wr;
      end
      ST_UL:                   hs_address = ul_addr;
      ST_SCAN_RD, ST_SCAN_ACC: hs_address = w_scan_addr;
      default: ;
    endcase
  end

  // Host stalls run from the cycle after detection until the port is theirs.
  assign dl_wait    = dl_active && (r_state != ST_IDLE) && (r_state != ST_DL);
  assign ul_wait    = ul_active && (r_state != ST_IDLE) && (r_state != ST_UL);
  assign pause_req  = r_pause_req;
  assign ul_data    = r_ul_data;
  assign upload_req = w_changed;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hs_port_arbiter.sv
// Self-checking bench for hs_port_arbiter with a core RAM and pause model.
module tb_hs_port_arbiter;
  import hs_port_arbiter_pkg::*;

  localparam int PAUSEPAD = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dl_active, dl_wr, dl_wait;
  logic [5:0] dl_addr;
  logic [7:0] dl_data;
  logic       ul_active, ul_wait;
  logic [5:0] ul_addr;
  logic [7:0] ul_data;
  logic       autosave_en, osd_open, pause_req, paused;
  logic [5:0] hs_address;
  logic [7:0] hs_data_in, hs_data_out;
  logic       hs_write, upload_req, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] exp;
  } ul_vec_t;
  ul_vec_t ul_tab [5];

  logic [15:0] sb_q [$];

  hs_port_arbiter #(.ADDR_W(6), .PAUSEPAD(PAUSEPAD), .CSUM_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
    .ul_active(ul_active), .ul_addr(ul_addr), .ul_data(ul_data), .ul_wait(ul_wait),
    .autosave_en(autosave_en), .osd_open(osd_open), .pause_req(pause_req), .paused(paused),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write), .hs_data_out(hs_data_out),
    .upload_req(upload_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core hiscore RAM: registered read, write strobe, bench-side poke port.
  logic [7:0] mem [64];
  logic       poke_en = 1'b0;
  logic [5:0] poke_addr = '0;
  logic [7:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_en)       mem[poke_addr] <= poke_data;
    else if (hs_write) mem[hs_address] <= hs_data_in;
    hs_data_out <= mem[hs_address];
  end

  // Pause block: paused follows pause_req three cycles later.
  logic [2:0] pz;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pz <= '0;
    else          pz <= {pz[1:0], pause_req};
  end
  assign paused = pz[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 80) begin tick(); n++; end
    chk(name, busy, 0);
  endtask

  task automatic wait_state(input string name, input state_t s);
    int n = 0;
    while (dut.r_state !== s && n < 80) begin tick(); n++; end
    chk(name, dut.r_state, s);
  endtask

  // One full scan triggered by an OSD edge from IDLE.
  task automatic run_scan(output int pad_edges, output int scan_cyc, output int upl,
                          output int drops, output int addr_err);
    int n;
    int rd_idx;
    pad_edges = 0; scan_cyc = 0; upl = 0; drops = 0; addr_err = 0; rd_idx = 0;
    osd_open = 1'b1;
    tick();
    osd_open = 1'b0;
    n = 0;
    while (paused !== 1'b1 && n < 40) begin tick(); n++; end
    chk("scan_paused_ack", paused, 1);
    n = 0;
    do begin tick(); n++; end while (dut.r_state !== ST_SCAN_RD && n < 20);
    pad_edges = n;
    while (is_scan_state(dut.r_state) && scan_cyc < 300) begin
      if (dut.r_state == ST_SCAN_RD) begin
        if (hs_address !== 6'(rd_idx)) addr_err++;
        rd_idx++;
      end
      if (pause_req !== 1'b1 || busy !== 1'b1) drops++;
      if (upload_req === 1'b1) upl++;
      scan_cyc++;
      tick();
    end
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      if (upload_req === 1'b1) upl++;
      tick();
      n++;
    end
    chk("scan_release_done", {pause_req, busy}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe, sc, up, dr, ae, n, seen, first_addr, rerun_done;
    logic [15:0] e;
    logic [15:0] prev_csum;

    ul_tab[0] = '{6'h3F, 8'h3F};
    ul_tab[1] = '{6'h05, 8'h10};
    ul_tab[2] = '{6'h00, 8'h00};
    ul_tab[3] = '{6'h2A, 8'h2A};
    ul_tab[4] = '{6'h11, 8'h11};

    reset_n = 1'b0; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
    ul_active = 0; ul_addr = '0; autosave_en = 0; osd_open = 0;
    repeat (3) tick();
    chk("reset_outputs", {pause_req, hs_write, hs_address, hs_data_in, ul_data, dl_wait, ul_wait, upload_req, busy}, 0);
    chk("reset_state", {dut.r_state, dut.u_scan.o_csum_valid, dut.u_scan.o_stored_csum}, {ST_IDLE, 17'h0});
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 64; i++) poke(6'(i), (i == 5) ? 8'h00 : 8'(i));

    // Edge with autosave disabled is ignored.
    osd_open = 1'b1;
    tick();
    osd_open = 1'b0;
    repeat (8) tick();
    chk("autosave_off_ignored", {busy, dut.r_scan_req}, 0);
    autosave_en = 1'b1;

    // First scan only records the baseline: sum(0..63) - 5 = 0x7DB.
    run_scan(pe, sc, up, dr, ae);
    chk("scan1_pad_edges", pe, PAUSEPAD + 1);
    chk("scan1_cycles", sc, 128);
    chk("scan1_pause_busy_held", dr, 0);
    chk("scan1_addr_seq", ae, 0);
    chk("scan1_no_upload", up, 0);
    chk("scan1_stored", {dut.u_scan.o_csum_valid, dut.u_scan.o_stored_csum}, {1'b1, 16'h07DB});
    prev_csum = dut.u_scan.o_stored_csum;

    // Core-side change at 0x05 must raise exactly one upload pulse.
    poke(6'h05, 8'h10);
    run_scan(pe, sc, up, dr, ae);
    chk("scan2_upload_pulses", up, 1);
    chk("scan2_stored", dut.u_scan.o_stored_csum, 16'h07EB);
    chk("scan2_delta", dut.u_scan.o_stored_csum - prev_csum, 16'h0010);

    // Upload reads, table driven through the scoreboard.
    ul_active = 1'b1;
    seen = 0;
    n = 0;
    while (dut.r_state !== ST_UL && n < 80) begin
      if (busy && ul_wait) seen = 1;
      tick();
      n++;
    end
    chk("ul_entered", dut.r_state, ST_UL);
    chk("ul_wait_before_ul", seen, 1);
    foreach (ul_tab[k]) begin
      ul_addr = ul_tab[k].addr;
      sb_q.push_back({8'h00, ul_tab[k].exp});
      tick();
      tick();
      e = sb_q.pop_front();
      chk($sformatf("ul_data_%0h", ul_tab[k].addr), ul_data, e[7:0]);
      chk("ul_wait_in_ul", {ul_wait, pause_req}, 2'b01);
    end
    ul_active = 1'b0;
    wait_idle("ul_release");

    // Download 64 bytes of 0xA5: stall until PAD completes, then pass-through.
    dl_active = 1'b1;
    n = 0;
    while (paused !== 1'b1 && n < 40) begin tick(); n++; end
    chk("dl_wait_paused", {paused, dl_wait}, 2'b11);
    tick();
    chk("dl_wait_pad1", dl_wait, 1);
    tick();
    chk("dl_wait_pad2", dl_wait, 1);
    tick();
    chk("dl_entered", {dut.r_state, dl_wait}, {ST_DL, 1'b0});
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      dl_addr = 6'(i);
      dl_data = 8'hA5;
      dl_wr   = 1'b1;
      sb_q.push_back({2'b00, 6'(i), 8'hA5});
      #1;
      if (hs_write === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        seen++;
        chk("dl_write_mirror", {hs_address, hs_data_in}, e[13:0]);
      end
      tick();
      dl_wr = 1'b0;
      #1;
      if (i == 10) chk("dl_write_gap", hs_write, 0);
      tick();
    end
    chk("dl_writes_seen", seen, 64);
    chk("dl_sb_empty", sb_q.size(), 0);
    dl_active = 1'b0;
    wait_idle("dl_release");

    // Scan after download records 64*0xA5 = 0x2940 silently.
    run_scan(pe, sc, up, dr, ae);
    chk("scan3_no_upload", up, 0);
    chk("scan3_stored", dut.u_scan.o_stored_csum, 16'h2940);

    // Preempt a scan at byte 20 with a download; the scan reruns afterwards.
    osd_open = 1'b1;
    tick();
    osd_open = 1'b0;
    n = 0;
    while (!(dut.r_state === ST_SCAN_RD && hs_address === 6'd20) && n < 200) begin tick(); n++; end
    chk("preempt_at_byte20", {dut.r_state, hs_address}, {ST_SCAN_RD, 6'd20});
    dl_active = 1'b1;
    tick();
    chk("preempt_in_dl", {dut.r_state, pause_req}, {ST_DL, 1'b1});
    repeat (3) tick();
    chk("preempt_kept_state", {dut.r_scan_req, dut.u_scan.o_stored_csum}, {1'b1, 16'h2940});
    dl_active = 1'b0;
    dr = 0; up = 0; sc = 0; first_addr = -1; rerun_done = 0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      if (!rerun_done && pause_req !== 1'b1) dr++;
      if (upload_req === 1'b1) up++;
      if (is_scan_state(dut.r_state)) sc++;
      if (dut.r_state == ST_SCAN_RD && first_addr < 0) first_addr = int'(hs_address);
      if (dut.r_state == ST_SCAN_ACC && hs_address == 6'h3F) rerun_done = 1;
      tick();
      n++;
    end
    chk("rerun_idle", busy, 0);
    chk("rerun_first_addr", first_addr, 0);
    chk("rerun_cycles", sc, 128);
    chk("rerun_pause_held", dr, 0);
    chk("rerun_no_upload", up, 0);
    chk("rerun_stored", {dut.r_scan_req, dut.u_scan.o_stored_csum}, {1'b0, 16'h2940});

    // Upload of 0x3F, then reset mid-UL.
    ul_active = 1'b1;
    wait_state("ul2_entered", ST_UL);
    ul_addr = 6'h3F;
    sb_q.push_back(16'h00A5);
    tick();
    tick();
    e = sb_q.pop_front();
    chk("ul2_data_3f", ul_data, e[7:0]);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_ul", {pause_req, hs_write, ul_wait, busy, upload_req, hs_address}, 0);
    tick();
    ul_active = 1'b0;
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_reset_idle", {dut.r_state, busy}, {ST_IDLE, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
